ssd_scan_decoder: RTL

SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

---
 rtl/ssd_scan_decoder_if.sv | 23 ++
 rtl/ssd_scan_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder_if.sv
// Bundle between a multiplexed 7-segment scanner (master) and its decoder (slave).
// The scanner drives the raw active-low segment/select lines; the decoder returns the captured frame state.
`timescale 1ns/1ps
interface ssd_scan_decoder_if;
  logic [7:0]  Segment;
  logic [5:0]  Digital;
  logic [23:0] DigitBcd;
  logic [5:0]  DecPoint;
  logic [5:0]  DigitValid;
  logic        FrameDone;
  logic        ScanError;
  logic        Active;

  modport master (
    output Segment, Digital,
    input  DigitBcd, DecPoint, DigitValid, FrameDone, ScanError, Active
  );

  modport slave (
    input  Segment, Digital,
    output DigitBcd, DecPoint, DigitValid, FrameDone, ScanError, Active
  );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Decodes a scanned 6-digit 7-segment display into BCD; a digit is captured SETTLE_CYCLES+1 edges
// after its select is registered and held stable. Input-only block: no backpressure, pulses are never held off.
`timescale 1ns/1ps
module ssd_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              Clock,
  input  logic              Reset,
  ssd_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_VAL = 20'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  seg_q, seg_d, seg_p_q, seg_p_d;
  logic [5:0]  dig_q, dig_d, dig_p_q, dig_p_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [19:0] tmo_q, tmo_d;
  logic [2:0]  exp_q, exp_d;
  logic [23:0] bcd_q, bcd_d;
  logic [5:0]  dp_q, dp_d;
  logic [5:0]  vld_q, vld_d;
  logic        frame_q, frame_d;
  logic        err_q, err_d;
  logic        active_q, active_d;

  logic [2:0]  zeros;
  logic [2:0]  sel_idx;
  logic        sel_idle, sel_legal, sel_illegal;
  logic        dig_chg, seg_chg;
  logic        capture, ill_err;
  logic [3:0]  dec_val;
  logic        dec_ok;

  // Select classification on the registered copy only.
  always_comb begin
    zeros   = '0;
    sel_idx = '0;
    for (int i = 0; i < 6; i++) begin
      if (!dig_q[i]) begin
        zeros   = zeros + 3'd1;
        sel_idx = 3'(i);
      end
    end
    sel_idle    = (zeros == 3'd0);
    sel_legal   = (zeros == 3'd1);
    sel_illegal = (zeros >= 3'd2);
    dig_chg     = (dig_q != dig_p_q);
    seg_chg     = (seg_q != seg_p_q);
  end

  always_comb begin
    dec_val = 4'hE;
    dec_ok  = 1'b1;
    case (seg_q[6:0])
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      7'h7F:   dec_val = 4'hF;
      default: dec_ok  = 1'b0;
    endcase
  end

  // FSM next state; an illegal select overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    ill_err = 1'b0;
    if (sel_illegal) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ill_err = dig_chg;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_legal) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end
        end
        S_SETTLE: begin
          if (sel_idle) begin
            state_d = S_IDLE;
          end else if (dig_chg || seg_chg) begin
            cnt_d = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (sel_idle) begin
            state_d = S_IDLE;
          end else if (dig_chg) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Capture, frame ordering and activity timeout.
  always_comb begin
    seg_d    = bus.Segment;
    dig_d    = bus.Digital;
    seg_p_d  = seg_q;
    dig_p_d  = dig_q;
    bcd_d    = bcd_q;
    dp_d     = dp_q;
    vld_d    = vld_q;
    exp_d    = exp_q;
    active_d = active_q;
    frame_d  = 1'b0;
    err_d    = ill_err;
    tmo_d    = (tmo_q == '1) ? tmo_q : tmo_q + 20'd1;
    if (capture) begin
      tmo_d    = '0;
      active_d = 1'b1;
      bcd_d[{sel_idx, 2'b00} +: 4] = dec_val;
      dp_d[sel_idx]  = ~seg_q[7];
      vld_d[sel_idx] = dec_ok;
      if (sel_idx == exp_q) begin
        if (sel_idx == 3'd5) begin
          frame_d = 1'b1;
          exp_d   = '0;
        end else begin
          exp_d = exp_q + 3'd1;
        end
      end else begin
        err_d = 1'b1;
        exp_d = (sel_idx == 3'd0) ? 3'd1 : 3'd0;
      end
    end else if (tmo_d == TIMEOUT_VAL) begin
      active_d = 1'b0;
      exp_d    = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      seg_q    <= '1;
      dig_q    <= '1;
      seg_p_q  <= '1;
      dig_p_q  <= '1;
      cnt_q    <= '0;
      tmo_q    <= '0;
      exp_q    <= '0;
      bcd_q    <= '1;
      dp_q     <= '0;
      vld_q    <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      seg_p_q  <= seg_p_d;
      dig_p_q  <= dig_p_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      exp_q    <= exp_d;
      bcd_q    <= bcd_d;
      dp_q     <= dp_d;
      vld_q    <= vld_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign bus.DigitBcd   = bcd_q;
  assign bus.DecPoint   = dp_q;
  assign bus.DigitValid = vld_q;
  assign bus.FrameDone  = frame_q;
  assign bus.ScanError  = err_q;
  assign bus.Active     = active_q;

endmodule
